// File: rtl/caf_ref_pkg.sv
// Shared types and constants for the reference buffer sequencer:
// sweep FSM state encoding and output FIFO sizing.
package caf_ref_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int FIFO_CNT_W = FIFO_PTR_W + 1;

endpackage

// File: rtl/ref_seq_fifo.sv
// First-word-fall-through FIFO for returned I/Q samples.
// A push into an empty FIFO is visible at the head in the same cycle, so a
// same-cycle push+pop on an empty FIFO passes straight through.
module ref_seq_fifo
  import caf_ref_pkg::*;
#(
  parameter int width = 24,
  parameter int depth = FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  logic [width-1:0]            data_i,
  input  logic                        pop_i,
  output logic                        valid_o,
  output logic [width-1:0]            data_o,
  output logic [$clog2(depth):0]      count_o
);

  localparam int PTR_W = $clog2(depth);
  localparam int CNT_W = PTR_W + 1;

  logic [width-1:0] mem_q [depth];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty, bypass, wr_en, rd_en;

  assign empty   = (cnt_q == '0);
  assign bypass  = push_i && pop_i && empty;
  assign wr_en   = push_i && !bypass;
  assign rd_en   = pop_i && !empty;
  assign valid_o = !empty || push_i;
  assign data_o  = empty ? data_i : mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state: pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Sample storage, no reset on data
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/reference_buffer_sequencer.sv
// Sweeps a range of reference buffer addresses (one read per cycle, credit
// limited) and forwards the I/Q returns through an FWFT output FIFO.
// Optional feature macro REF_SEQ_WRAP_EN: address wraps from the last buffer
// index to 0; without it, sweeps running past the buffer end are rejected.
module reference_buffer_sequencer
  import caf_ref_pkg::*;
#(
  parameter int buffer_length = 10,
  parameter int index_bits    = 4,
  parameter int i_bits        = 12,
  parameter int q_bits        = 12,
  parameter int fifo_depth    = FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [index_bits-1:0]     cmd_start,
  input  logic [index_bits:0]       cmd_len,
  output logic                      buf_rvalid,
  output logic                      buf_rready,
  output logic [index_bits-1:0]     buf_raddr,
  input  logic                      buf_dvalid,
  input  logic signed [i_bits-1:0]  buf_i,
  input  logic signed [q_bits-1:0]  buf_q,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [i_bits-1:0]  out_i,
  output logic signed [q_bits-1:0]  out_q,
  output logic                      done,
  output logic                      err
);

  localparam int LEN_W = index_bits + 1;
  localparam int CNT_W = $clog2(fifo_depth) + 1;
  localparam int DW    = i_bits + q_bits;
  localparam logic [LEN_W-1:0] BL_LEN = LEN_W'(buffer_length);

  seq_state_e              state_q, state_d;
  logic [index_bits-1:0]   addr_q, addr_d, addr_next;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        issued_q, issued_d;
  logic [LEN_W-1:0]        rcv_q, rcv_d;
  logic [CNT_W-1:0]        credits_q, credits_d;
  logic                    err_q, err_d;

  logic                    accept, illegal, issue, push, pop, drain_done;
  logic [LEN_W-1:0]        start_ext;
  logic [CNT_W-1:0]        fifo_cnt;
  logic [CNT_W:0]          occ_next;
  logic [DW-1:0]           fifo_data;

  assign start_ext  = {1'b0, cmd_start};
  assign cmd_ready  = (state_q == ST_IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign issue      = (state_q == ST_ISSUE) && (credits_q != '0);
  assign push       = buf_dvalid && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
  assign pop        = out_valid && out_ready;
  assign occ_next   = {1'b0, fifo_cnt} + (CNT_W+1)'(push) - (CNT_W+1)'(pop);
  // Last sample leaves the FIFO this cycle: nothing left to receive or hold
  assign drain_done = ((rcv_q + LEN_W'(push)) == len_q) && (occ_next == '0);

`ifdef REF_SEQ_WRAP_EN
  localparam logic [index_bits-1:0] LAST_IDX = index_bits'(buffer_length - 1);
  assign illegal   = (start_ext >= BL_LEN) || (cmd_len > BL_LEN);
  assign addr_next = (addr_q == LAST_IDX) ? '0 : addr_q + 1'b1;
`else
  logic [LEN_W:0] span;
  assign span      = {1'b0, start_ext} + {1'b0, cmd_len};
  assign illegal   = (start_ext >= BL_LEN) || (cmd_len > BL_LEN) || (span > {1'b0, BL_LEN});
  assign addr_next = addr_q + 1'b1;
`endif

  assign buf_rvalid = issue;
  assign buf_rready = issue;
  assign buf_raddr  = addr_q;
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign out_i      = out_valid ? fifo_data[DW-1:q_bits] : '0;
  assign out_q      = out_valid ? fifo_data[q_bits-1:0]  : '0;

  // Sweep FSM, counters and credit next-state
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    issued_d  = issued_q;
    rcv_d     = rcv_q + LEN_W'(push);
    err_d     = 1'b0;
    credits_d = credits_q;
    case ({issue, pop})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            addr_d   = cmd_start;
            len_d    = cmd_len;
            issued_d = '0;
            rcv_d    = '0;
            state_d  = (cmd_len == '0) ? ST_DONE : ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (issue) begin
          addr_d   = addr_next;
          issued_d = issued_q + 1'b1;
          if ((issued_q + 1'b1) == len_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_done) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      issued_q  <= '0;
      rcv_q     <= '0;
      credits_q <= CNT_W'(fifo_depth);
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      issued_q  <= issued_d;
      rcv_q     <= rcv_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  ref_seq_fifo #(
    .width (DW),
    .depth (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  ({buf_i, buf_q}),
    .pop_i   (pop),
    .valid_o (out_valid),
    .data_o  (fifo_data),
    .count_o (fifo_cnt)
  );

  // Credits must keep returns from ever landing on a full FIFO
  ovf_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (fifo_cnt == CNT_W'(fifo_depth))));

endmodule

// File: tb/tb_reference_buffer_sequencer.sv
// Self-checking bench for reference_buffer_sequencer (buffer_length=10,
// fifo_depth=4). Honours REF_SEQ_WRAP_EN the same way the design does.
module tb_reference_buffer_sequencer;

  localparam int BL    = 10;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [3:0]         cmd_start = '0;
  logic [4:0]         cmd_len = '0;
  logic               buf_rvalid, buf_rready;
  logic [3:0]         buf_raddr;
  logic               buf_dvalid;
  logic signed [11:0] buf_i, buf_q;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [11:0] out_i, out_q;
  logic               done, err;

  always #5 clk = ~clk;

  reference_buffer_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_start(cmd_start), .cmd_len(cmd_len),
    .buf_rvalid(buf_rvalid), .buf_rready(buf_rready), .buf_raddr(buf_raddr),
    .buf_dvalid(buf_dvalid), .buf_i(buf_i), .buf_q(buf_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_q(out_q),
    .done(done), .err(err)
  );

  // Reference buffer: fixed random contents, data returned 2 cycles after request
  logic signed [11:0] ref_i [BL];
  logic signed [11:0] ref_q [BL];
  logic       p1_v = 1'b0, p2_v = 1'b0;
  logic [3:0] p1_a = '0,   p2_a = '0;
  always @(posedge clk) begin
    p1_v <= buf_rvalid;
    p1_a <= buf_raddr;
    p2_v <= p1_v;
    p2_a <= p1_a;
  end
  assign buf_dvalid = p2_v;
  assign buf_i = (p2_v && p2_a < BL) ? ref_i[p2_a] : '0;
  assign buf_q = (p2_v && p2_a < BL) ? ref_q[p2_a] : '0;

  // Downstream ready: 0 = always ready, 1 = random, 2 = stalled
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Behavioural model state: one sweep in flight at most
  bit  m_busy = 0, m_done_due = 0, m_err_due = 0;
  int  m_len = 0, m_issued = 0, m_pushed = 0, m_popped = 0;
  int  q_addr[$];
  int  obs_addr[$];
  int  obs_data[$];
  int  n_rvalid = 0, err_cnt = 0, done_cnt = 0;
  int  cyc_n = 0, t_acc = 0, t_done = 0, t_ov = -1;

  // Compare process: checks every output each cycle against the model
  always @(negedge clk) begin
    bit busy0, exp_rv, pushed_now, exp_ov, popped_now, legal;
    int s, l;
    cyc_n++;
    if (!rst_n) begin
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_buf_rvalid", buf_rvalid, 0);
      chk("rst_buf_rready", buf_rready, 0);
      chk("rst_buf_raddr", buf_raddr, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_i", out_i, 0);
      chk("rst_out_q", out_q, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      m_busy = 0; m_done_due = 0; m_err_due = 0;
      m_len = 0; m_issued = 0; m_pushed = 0; m_popped = 0;
      q_addr.delete();
    end else begin
      busy0 = m_busy;
      chk("cmd_ready", cmd_ready, !m_busy);
      chk("done", done, m_done_due);
      chk("err", err, m_err_due);
      if (err) err_cnt++;
      if (done) begin done_cnt++; t_done = cyc_n; end
      // A read may go out while reads remain and fewer than DEPTH samples are unpopped
      exp_rv = m_busy && (m_issued < m_len) && ((m_issued - m_popped) < DEPTH);
      chk("buf_rvalid", buf_rvalid, exp_rv);
      chk("buf_rready", buf_rready, buf_rvalid);
      if (buf_rvalid) begin
        n_rvalid++;
        obs_addr.push_back(int'(buf_raddr));
        if (m_issued < q_addr.size()) chk("buf_raddr", buf_raddr, q_addr[m_issued]);
        if (m_busy) m_issued++;
      end
      pushed_now = m_busy && buf_dvalid;
      exp_ov = m_busy && ((m_pushed + int'(pushed_now)) > m_popped);
      chk("out_valid", out_valid, exp_ov);
      if (out_valid && t_ov < 0) t_ov = cyc_n;
      popped_now = out_valid && out_ready && exp_ov && (m_popped < q_addr.size());
      if (popped_now) begin
        chk("out_i", out_i, ref_i[q_addr[m_popped]]);
        chk("out_q", out_q, ref_q[q_addr[m_popped]]);
        obs_data.push_back(int'(out_i));
        m_popped++;
      end
      m_pushed += int'(pushed_now);
      if (m_done_due) begin m_done_due = 0; m_busy = 0; end
      m_err_due = 0;
      if (popped_now && m_popped == m_len) m_done_due = 1;
      if (!busy0 && cmd_valid) begin
        s = int'(cmd_start);
        l = int'(cmd_len);
        legal = (s < BL) && (l <= BL);
`ifndef REF_SEQ_WRAP_EN
        legal = legal && (s + l <= BL);
`endif
        if (!legal) begin
          m_err_due = 1;
        end else begin
          m_busy = 1; m_len = l; m_issued = 0; m_pushed = 0; m_popped = 0;
          t_acc = cyc_n; t_ov = -1;
          q_addr.delete();
          for (int i = 0; i < l; i++) q_addr.push_back((s + i) % BL);
          if (l == 0) m_done_due = 1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int s, input int l);
    cmd_start = 4'(s);
    cmd_len   = 5'(l);
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (m_busy && n < bound) begin tick(1); n++; end
    chk(name, m_busy, 0);
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
  endtask

  initial begin
    int e0, d0, r0, s, l;
    for (int i = 0; i < BL; i++) begin
      ref_i[i] = 12'($urandom);
      ref_q[i] = 12'($urandom);
    end
    tick(3);
    rst_n = 1'b1;
    chk("post_reset_cmd_ready", cmd_ready, 1);

    // Full sweep, always ready: addrs 0..9, accept->first out 3, accept->done 13
    clear_obs();
    send(0, 10);
    wait_idle("t1_timeout", 100);
    chk("t1_naddr", obs_addr.size(), 10);
    for (int i = 0; i < obs_addr.size() && i < 10; i++) chk("t1_addr", obs_addr[i], i);
    chk("t1_ndata", obs_data.size(), 10);
    for (int i = 0; i < obs_data.size() && i < 10; i++) chk("t1_data", obs_data[i], ref_i[i]);
    chk("t1_first_out", t_ov - t_acc, 3);
    chk("t1_done_at", t_done - t_acc, 13);

    // Sweep running past the buffer end
    clear_obs();
    e0 = err_cnt;
    send(7, 5);
`ifdef REF_SEQ_WRAP_EN
    wait_idle("t2_timeout", 100);
    chk("t2_naddr", obs_addr.size(), 5);
    if (obs_addr.size() == 5) begin
      chk("t2_a0", obs_addr[0], 7); chk("t2_a1", obs_addr[1], 8); chk("t2_a2", obs_addr[2], 9);
      chk("t2_a3", obs_addr[3], 0); chk("t2_a4", obs_addr[4], 1);
    end
    chk("t2_err", err_cnt - e0, 0);
`else
    tick(3);
    chk("t2_err", err_cnt - e0, 1);
    chk("t2_naddr", obs_addr.size(), 0);
    chk("t2_cmd_ready", cmd_ready, 1);
`endif

    // Downstream stall: only DEPTH reads go out, then release
    clear_obs();
    rdy_mode = 2;
    tick(1);
    r0 = n_rvalid;
    send(0, 10);
    tick(20);
    chk("t3_nreq_stalled", n_rvalid - r0, 4);
    chk("t3_out_valid", out_valid, 1);
    rdy_mode = 0;
    wait_idle("t3_timeout", 100);
    chk("t3_ndata", obs_data.size(), 10);
    for (int i = 0; i < obs_data.size() && i < 10; i++) chk("t3_data", obs_data[i], ref_i[i]);

    // Illegal commands and the zero-length no-op
    clear_obs();
    e0 = err_cnt; d0 = done_cnt;
    send(10, 1);
    tick(1);
    send(0, 11);
    tick(2);
    chk("t4_err", err_cnt - e0, 2);
    chk("t4_cmd_ready", cmd_ready, 1);
    send(3, 0);
    tick(3);
    chk("t4_done_len0", done_cnt - d0, 1);
    chk("t4_naddr", obs_addr.size(), 0);

    // Reset in the middle of a sweep, then a short sweep
    clear_obs();
    send(0, 10);
    begin
      int n = 0;
      while (obs_addr.size() < 3 && n < 50) begin tick(1); n++; end
      chk("t5_reach3", obs_addr.size() >= 3, 1);
    end
    rst_n = 1'b0;
    #1;
    chk("t5_async_rvalid", buf_rvalid, 0);
    chk("t5_async_out_valid", out_valid, 0);
    chk("t5_async_cmd_ready", cmd_ready, 1);
    tick(4);
    rst_n = 1'b1;
    tick(1);
    clear_obs();
    send(2, 3);
    wait_idle("t5_timeout", 100);
    chk("t5_ndata", obs_data.size(), 3);
    for (int i = 0; i < obs_data.size() && i < 3; i++) chk("t5_data", obs_data[i], ref_i[2 + i]);

    // Random commands with random downstream ready
    rdy_mode = 1;
    clear_obs();
    send(0, 10);
    wait_idle("t6_full_timeout", 300);
    chk("t6_full_ndata", obs_data.size(), 10);
    for (int k = 0; k < 12; k++) begin
      s = $urandom_range(0, 10);
      l = $urandom_range(0, 11);
      send(s, l);
      wait_idle("t6_timeout", 300);
      tick(2);
    end
    rdy_mode = 0;
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
